// File: rtl/irr_pkg.sv
// Shared types and default tuning constants for the irrigation sequencer.
// The optional tank fill valve is built only when TANK_FILL_EN is defined.
package irr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPRINKLE,
    ST_DRIP,
    ST_COOL,
    ST_FAULT
  } irr_state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_MIN_ON     = 8;
  localparam int DEF_MAX_ON     = 64;
  localparam int DEF_COOL       = 16;

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Sensor inputs and actuator/flag outputs of the irrigation sequencer.
// The master side drives the sensors; the sequencer sits on the slave side.
interface irrigation_sequencer_if;

  logic H, M, L;
  logic Ua, Us, T;
  logic E, Al;
  logic Bs, Vs;
  logic Vf;

  modport master (
    output H, M, L, Ua, Us, T,
    input  E, Al, Bs, Vs, Vf
  );

  modport slave (
    input  H, M, L, Ua, Us, T,
    output E, Al, Bs, Vs, Vf
  );

endinterface

// File: rtl/sensor_debounce.sv
// One-bit debouncer: the output follows the raw input only after the raw
// value has differed from it for DEB_CYCLES consecutive cycles.
module sensor_debounce #(
  parameter int   DEB_CYCLES = 4,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

  logic [3:0] cnt;

  // Any cycle where raw agrees with the accepted value restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= RST_VAL;
      cnt <= 4'd0;
    end else if (raw == deb) begin
      cnt <= 4'd0;
    end else if (cnt == CNT_LAST) begin
      deb <= raw;
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation controller: debounced tank/climate sensors drive a sprinkler
// and drip FSM with min/max run time and cooldown. Optional TANK_FILL_EN.
module irrigation_sequencer
  import irr_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int MIN_ON     = DEF_MIN_ON,
  parameter int MAX_ON     = DEF_MAX_ON,
  parameter int COOL       = DEF_COOL
) (
  input logic                   clk,
  input logic                   rst,
  irrigation_sequencer_if.slave bus
);

  localparam int RW = $clog2(MAX_ON + 1);
  localparam int CW = $clog2(COOL + 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(MAX_ON - 1);
  localparam logic [RW-1:0] MIN_LAST  = RW'(MIN_ON - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL - 1);

  logic h_d, m_d, l_d, ua_d, us_d, t_d;
  logic fault, low, stop, sprk_req, drip_req;
  logic e_q, al_q;
  irr_state_t state, next_state;
  logic [RW-1:0] run_cnt;
  logic [CW-1:0] cool_cnt;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_h
    (.clk(clk), .rst(rst), .raw(bus.H), .deb(h_d));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_m
    (.clk(clk), .rst(rst), .raw(bus.M), .deb(m_d));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_l
    (.clk(clk), .rst(rst), .raw(bus.L), .deb(l_d));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_ua
    (.clk(clk), .rst(rst), .raw(bus.Ua), .deb(ua_d));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_us
    (.clk(clk), .rst(rst), .raw(bus.Us), .deb(us_d));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_t
    (.clk(clk), .rst(rst), .raw(bus.T), .deb(t_d));

  // A level reading with a gap below a wet sensor means a broken sensor.
  assign fault    = (h_d & ~m_d) | (m_d & ~l_d);
  assign low      = ~l_d;
  assign stop     = fault | low;
  assign sprk_req = ~us_d & (~ua_d | (m_d & ~t_d));
  assign drip_req = ~us_d & ua_d & (t_d | ~m_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q  <= 1'b0;
      al_q <= 1'b0;
    end else begin
      e_q  <= fault;
      al_q <= fault | low;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      run_cnt  <= '0;
      cool_cnt <= '0;
    end else begin
      state    <= next_state;
      run_cnt  <= ((next_state == state) && ((state == ST_SPRINKLE) || (state == ST_DRIP)))
                  ? run_cnt + 1'b1 : '0;
      cool_cnt <= ((next_state == state) && (state == ST_COOL)) ? cool_cnt + 1'b1 : '0;
    end
  end

  // Sensor trouble pre-empts everything, including the minimum on-time.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (stop)          next_state = ST_FAULT;
        else if (sprk_req) next_state = ST_SPRINKLE;
        else if (drip_req) next_state = ST_DRIP;
      end
      ST_SPRINKLE: begin
        if (stop)                                 next_state = ST_FAULT;
        else if (run_cnt == RUN_LAST)             next_state = ST_COOL;
        else if (!sprk_req && run_cnt >= MIN_LAST) next_state = ST_IDLE;
      end
      ST_DRIP: begin
        if (stop)                                 next_state = ST_FAULT;
        else if (run_cnt == RUN_LAST)             next_state = ST_COOL;
        else if (!drip_req && run_cnt >= MIN_LAST) next_state = ST_IDLE;
      end
      ST_COOL: begin
        if (stop)                       next_state = ST_FAULT;
        else if (cool_cnt == COOL_LAST) next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (!stop) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.E  = e_q;
  assign bus.Al = al_q;
  assign bus.Bs = (state == ST_SPRINKLE);
  assign bus.Vs = (state == ST_DRIP);

`ifdef TANK_FILL_EN
  logic vf_q;

  // Fill valve tracks tank level on its own, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst)              vf_q <= 1'b0;
    else if (h_d | fault) vf_q <= 1'b0;
    else if (!m_d)        vf_q <= 1'b1;
  end

  assign bus.Vf = vf_q;
`else
  assign bus.Vf = 1'b0;
`endif

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed self-checking bench for irrigation_sequencer (default parameters).
// Define TANK_FILL_EN for the bench and the design together.
module tb_irrigation_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef TANK_FILL_EN
  localparam logic VF_FILL = 1'b1;
`else
  localparam logic VF_FILL = 1'b0;
`endif

  irrigation_sequencer_if bus ();

  irrigation_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic h, m, l, ua, us, t);
    bus.H  = h;
    bus.M  = m;
    bus.L  = l;
    bus.Ua = ua;
    bus.Us = us;
    bus.T  = t;
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with all sensors at their safe values
    apply_stimulus(1, 1, 1, 1, 1, 0);
    rst = 1'b1;
    tick(2);
    check_output("rst_E", bus.E, 1'b0);
    check_output("rst_Al", bus.Al, 1'b0);
    check_output("rst_Bs", bus.Bs, 1'b0);
    check_output("rst_Vs", bus.Vs, 1'b0);
    check_output("rst_Vf", bus.Vf, 1'b0);

    // dry soil, dry air: sprinkler at edge 5
    rst = 1'b0;
    apply_stimulus(1, 1, 1, 0, 0, 0);
    tick(4);
    check_output("lat_Bs_edge4", bus.Bs, 1'b0);
    tick(1);
    check_output("lat_Bs_edge5", bus.Bs, 1'b1);
    check_output("lat_Vs_edge5", bus.Vs, 1'b0);

    // soil wet again at run_cnt=2: min on-time keeps Bs through run_cnt=7
    tick(2);
    bus.Us = 1'b1;
    tick(4);
    check_output("minon_Bs_rc6", bus.Bs, 1'b1);
    tick(1);
    check_output("minon_Bs_rc7", bus.Bs, 1'b1);
    tick(1);
    check_output("minon_Bs_idle", bus.Bs, 1'b0);

    // 3-cycle glitch on Us must be ignored
    bus.Us = 1'b0;
    tick(3);
    bus.Us = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_output("glitch_Bs", bus.Bs, 1'b0);
    end
    check_output("glitch_Vs", bus.Vs, 1'b0);

    // permanent request: 64 on, 16 cooldown, back on after IDLE
    bus.Us = 1'b0;
    tick(5);
    check_output("maxon_Bs_rc0", bus.Bs, 1'b1);
    tick(63);
    check_output("maxon_Bs_rc63", bus.Bs, 1'b1);
    tick(1);
    check_output("cool_Bs_first", bus.Bs, 1'b0);
    tick(15);
    check_output("cool_Bs_last", bus.Bs, 1'b0);
    tick(2);
    check_output("cool_Bs_again", bus.Bs, 1'b1);
    bus.Us = 1'b1;
    tick(12);
    check_output("release_Bs", bus.Bs, 1'b0);

    // drip, then low tank forces FAULT, recovery goes through IDLE
    apply_stimulus(1, 1, 1, 1, 0, 1);
    tick(5);
    check_output("drip_Vs_on", bus.Vs, 1'b1);
    check_output("drip_Bs_off", bus.Bs, 1'b0);
    tick(3);
    bus.L = 1'b0;
    tick(4);
    check_output("low_Vs_edge4", bus.Vs, 1'b1);
    check_output("low_Al_edge4", bus.Al, 1'b0);
    tick(1);
    check_output("low_Vs_edge5", bus.Vs, 1'b0);
    check_output("low_Al_edge5", bus.Al, 1'b1);
    check_output("low_E_edge5", bus.E, 1'b1);
    bus.L = 1'b1;
    tick(5);
    check_output("recov_Vs_idle", bus.Vs, 1'b0);
    check_output("recov_Al", bus.Al, 1'b0);
    check_output("recov_E", bus.E, 1'b0);
    tick(1);
    check_output("recov_Vs_drip", bus.Vs, 1'b1);

    // mid-run reset drops the valve immediately
    rst = 1'b1;
    tick(1);
    check_output("midrst_Vs", bus.Vs, 1'b0);
    apply_stimulus(1, 1, 1, 1, 1, 0);
    rst = 1'b0;
    tick(6);
    check_output("midrst_Vs_after", bus.Vs, 1'b0);
    check_output("midrst_Bs_after", bus.Bs, 1'b0);

    // tank below medium: fill valve opens, closes when full
    apply_stimulus(0, 0, 1, 1, 1, 0);
    tick(5);
    check_output("fill_Vf_open", bus.Vf, VF_FILL);
    check_output("fill_E", bus.E, 1'b0);
    check_output("fill_Bs", bus.Bs, 1'b0);
    apply_stimulus(1, 1, 1, 1, 1, 0);
    tick(5);
    check_output("fill_Vf_closed", bus.Vf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter: DEB_CYCLES, 4, consecutive stable cycles before a sensor input is accepted (range 1..15).
REQ-002 Parameter: MIN_ON, 8, minimum cycles a pump/valve stays on once started (≥1).
REQ-003 Parameter: MAX_ON, 64, maximum continuous on-cycles before forced cooldown (MAX_ON > MIN_ON).
REQ-004 Parameter: COOL, 16, cooldown cycles with all actuators off.
REQ-005 Port: clk, input, 1, single clock; all logic is rising-edge.
REQ-006 Port: rst, input, 1, reset, synchronous and active-high.
REQ-007 Ports: H, M, L, input, 1 each, tank level sensors (high/medium/low; 1 = water present).
REQ-008 Ports: Ua, Us, T, input, 1 each, air humidity, soil humidity (1 = wet), temperature (1 = hot).
REQ-009 Ports: E, Al, output, 1 each, registered sensor-error and alarm flags.
REQ-010 Ports: Bs, Vs, output, 1 each, sprinkler pump and drip valve enables.
REQ-011 Port: Vf, output, 1, tank fill valve enable.

Function
REQ-012 Each input is debounced: the debounced value takes the raw value at the edge the raw value has been stable for DEB_CYCLES consecutive cycles; any change restarts that input's counter.
REQ-013 Derived signals use debounced values only:
- fault = (H & ~M) | (M & ~L)
- low = ~L
- sprk_req = ~Us & (~Ua | (M & ~T))
- drip_req = ~Us & Ua & (T | ~M)
sprk_req and drip_req are never both 1.
REQ-014 E <= fault and Al <= fault | low, registered one cycle after the debounced change.
REQ-015 FSM states: IDLE, SPRINKLE, DRIP, COOL, FAULT.
- Bs = 1 only in SPRINKLE.
- Vs = 1 only in DRIP.
- Both are decoded from the state register (Moore).
REQ-016 IDLE transitions, by priority:
- fault | low → FAULT
- sprk_req → SPRINKLE
- drip_req → DRIP
- otherwise stay in IDLE.
REQ-017 SPRINKLE/DRIP behaviour:
- run_cnt clears on entry and increments each cycle.
- fault | low → FAULT at the next edge, regardless of MIN_ON.
- run_cnt == MAX_ON-1 → COOL.
- Own request low and run_cnt ≥ MIN_ON-1 → IDLE.
- Request switching to the other type counts as deassertion.
REQ-018 COOL lasts exactly COOL cycles, then goes to IDLE; fault | low during COOL → FAULT.
REQ-019 FAULT holds Bs = Vs = 0 and goes to IDLE on the first cycle fault | low is 0.
REQ-020 Latency: a raw request held stable from cycle 0 raises Bs/Vs at edge DEB_CYCLES+1.

Reset
REQ-021 While rst = 1, at each edge:
- state ← IDLE; all counters ← 0.
- Debounced values ← H=M=L=1, Ua=Us=1, T=0.
- E = Al = Bs = Vs = Vf = 0.
REQ-022 rst asserted mid-run turns Bs/Vs off at that edge, with no cooldown.

Configuration
REQ-023 Macro TANK_FILL_EN, when defined:
- Vf is a registered flag: it sets when debounced M = 0 and no fault, and clears when debounced H = 1 or fault.
- Vf is independent of the FSM.
REQ-024 Without TANK_FILL_EN, Vf is constant 0 and no fill logic exists; the port is still present.

Structure
REQ-025 Shared package irr_pkg holds the FSM state enum and default parameter constants.
REQ-026 Sub-module sensor_debounce (1-bit, DEB_CYCLES parameter, reset value parameter) is instantiated six times.

Verification
REQ-027 Dry soil, dry air: Us=0, Ua=0, others safe (H=M=L=1) from cycle 0 → Bs=1 at edge 5, Vs=0.
REQ-028 Us=0 for 3 cycles then 1 (glitch shorter than DEB_CYCLES) → Bs and Vs stay 0.
REQ-029 Sprinkling, Us returns to 1 at run_cnt=2 → Bs stays 1 until run_cnt=7, then IDLE.
REQ-030 Request held permanently → Bs high 64 cycles, low 16 cycles (COOL), then high again.
REQ-031 Drip running (Ua=1, T=1), then L=0 → Al=1 and Vs=0 within DEB_CYCLES+1 cycles; L=1 restores → returns to IDLE.
REQ-032 With TANK_FILL_EN: M=L=1→M=0 → Vf=1; then H=1, M=1 → Vf=0. Without the macro, Vf=0 throughout.
